// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for the 8-bit ALU.
// It owns the accumulator, registers the ALU inputs, and captures the ALU
// result one cycle later. The response is held until it is accepted.
module alu_cmd_sequencer #(
  parameter logic [7:0] DIV0_RESULT = 8'hFF,
  parameter logic [7:0] ACC_RESET   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_operand_a,
  output logic [7:0] alu_operand_b,
  output logic [3:0] alu_operation,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_div0,
  output logic [7:0] acc
);

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 4;
  localparam logic [OW-1:0] OP_ADD = 4'b0000;
  localparam logic [OW-1:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [DW-1:0]   r_acc;
  logic [DW-1:0]   r_alu_operand_a;
  logic [DW-1:0]   r_alu_operand_b;
  logic [OW-1:0]   r_alu_operation;
  logic [DW-1:0]   r_rsp_result;
  logic            r_rsp_carry;
  logic            r_rsp_div0;
  logic            w_cmd_fire;
  logic            w_rsp_fire;
  logic            w_div0;

  assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);
  assign w_rsp_fire = rsp_ready && (r_state == ST_RESP);
  assign w_div0     = (r_alu_operation == OP_DIV) && (r_alu_operand_b == DW'(0));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: loads skip EXEC, ALU ops spend exactly one cycle there
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_state_next = cmd_load ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: begin
        if (w_rsp_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, result/accumulator capture in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc           <= ACC_RESET;
      r_alu_operand_a <= '0;
      r_alu_operand_b <= '0;
      r_alu_operation <= '0;
      r_rsp_result    <= '0;
      r_rsp_carry     <= 1'b0;
      r_rsp_div0      <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        if (cmd_load) begin
          r_acc        <= cmd_data;
          r_rsp_result <= cmd_data;
          r_rsp_carry  <= 1'b0;
          r_rsp_div0   <= 1'b0;
        end else begin
          r_alu_operand_a <= r_acc;
          r_alu_operand_b <= cmd_data;
          r_alu_operation <= cmd_op;
        end
      end else if (r_state == ST_EXEC) begin
        // Carry is only meaningful for ADD; the ALU drives it for every op
        r_rsp_carry <= alu_carry && (r_alu_operation == OP_ADD);
        if (w_div0) begin
          r_rsp_result <= DIV0_RESULT;
          r_rsp_div0   <= 1'b1;
        end else begin
          r_rsp_result <= alu_result;
          r_rsp_div0   <= 1'b0;
          r_acc        <= alu_result;
        end
      end
    end
  end

  // Outputs: handshake flags decoded from state, payload straight from registers
  assign cmd_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_result    = r_rsp_result;
  assign rsp_carry     = r_rsp_carry;
  assign rsp_div0      = r_rsp_div0;
  assign rsp_zero      = (r_rsp_result == DW'(0));
  assign acc           = r_acc;
  assign alu_operand_a = r_alu_operand_a;
  assign alu_operand_b = r_alu_operand_b;
  assign alu_operation = r_alu_operation;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural ALU, transaction-level model,
// directed table, reset and backpressure sequences, and random commands.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] alu_operand_a;
  logic [7:0] alu_operand_b;
  logic [3:0] alu_operation;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_div0;
  logic [7:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: accumulator and expected ALU input registers
  logic [7:0] m_acc = 8'h00;
  logic [7:0] e_a   = 8'h00;
  logic [7:0] e_b   = 8'h00;
  logic [3:0] e_op  = 4'h0;

  alu_cmd_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_load      (cmd_load),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero),
    .rsp_div0      (rsp_div0),
    .acc           (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational ALU
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[7:0];
      4'h3: return (b == 8'h00) ? 8'h00 : a / b;
      4'h5: return (a < b) ? 8'h01 : 8'h00;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  always_comb begin
    logic [8:0] s;
    s          = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
    alu_result = alu_f(alu_operation, alu_operand_a, alu_operand_b);
    alu_carry  = s[8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what the response should be for one command
  task automatic model_cmd(input logic ld, input logic [3:0] op, input logic [7:0] d,
                           output logic [7:0] r, output logic c, output logic dz);
    logic [8:0] sum;
    if (ld) begin
      r = d; c = 1'b0; dz = 1'b0; m_acc = d;
    end else begin
      e_a = m_acc; e_b = d; e_op = op;
      sum = {1'b0, m_acc} + {1'b0, d};
      c   = (op == 4'h0) ? sum[8] : 1'b0;
      if (op == 4'h3 && d == 8'h00) begin
        r = 8'hFF; dz = 1'b1;
      end else begin
        r = alu_f(op, m_acc, d); dz = 1'b0; m_acc = r;
      end
    end
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] r, input logic c, input logic dz);
    check({tag, "_result"}, 32'(rsp_result), 32'(r));
    check({tag, "_carry"},  32'(rsp_carry),  32'(c));
    check({tag, "_zero"},   32'(rsp_zero),   32'(r == 8'h00));
    check({tag, "_div0"},   32'(rsp_div0),   32'(dz));
    check({tag, "_acc"},    32'(acc),        32'(m_acc));
  endtask

  // One command end to end; called and returning on a negedge
  task automatic run_cmd(input logic ld, input logic [3:0] op, input logic [7:0] d, input int hold,
                         output logic [7:0] o_res, output logic o_c, output logic o_z,
                         output logic o_dz, output logic [7:0] o_acc);
    logic [7:0] r;
    logic c, dz;
    int n, lat;
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    model_cmd(ld, op, d, r, c, dz);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    check("rsp_latency", 32'(lat), ld ? 32'd1 : 32'd2);
    check_rsp("rsp", r, c, dz);
    check("alu_a",  32'(alu_operand_a), 32'(e_a));
    check("alu_b",  32'(alu_operand_b), 32'(e_b));
    check("alu_op", 32'(alu_operation), 32'(e_op));
    o_res = rsp_result; o_c = rsp_carry; o_z = rsp_zero; o_dz = rsp_div0; o_acc = acc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(cmd_ready), 32'd0);
      check("hold_result", 32'(rsp_result), 32'(r));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] op;
    logic [7:0] d;
    int         hold;
    logic [7:0] x_res;
    logic       x_c;
    logic       x_z;
    logic       x_dz;
    logic [7:0] x_acc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] o_res, o_acc, r;
    logic o_c, o_z, o_dz, c, dz;
    int lat;

    vecs[0] = '{1'b1, 4'h0, 8'hF0, 0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'hF0};
    vecs[1] = '{1'b0, 4'h0, 8'h20, 1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h10};
    vecs[2] = '{1'b1, 4'h0, 8'h40, 0, 8'h40, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[3] = '{1'b0, 4'h3, 8'h00, 2, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h40};
    vecs[4] = '{1'b0, 4'h3, 8'h08, 0, 8'h08, 1'b0, 1'b0, 1'b0, 8'h08};
    vecs[5] = '{1'b1, 4'h0, 8'hFF, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[6] = '{1'b0, 4'h8, 8'hFF, 3, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[7] = '{1'b1, 4'h0, 8'h10, 0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10};
    vecs[8] = '{1'b0, 4'h2, 8'h10, 1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[9] = '{1'b1, 4'h0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 4'h0;
    cmd_data = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_acc", 32'(acc), 32'h00);
    check("rst_rsp_result", 32'(rsp_result), 32'h00);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
    check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    check("rst_rsp_div0", 32'(rsp_div0), 32'd0);
    check("rst_alu_a", 32'(alu_operand_a), 32'h00);
    check("rst_alu_b", 32'(alu_operand_b), 32'h00);
    check("rst_alu_op", 32'(alu_operation), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[k]) begin
      run_cmd(vecs[k].ld, vecs[k].op, vecs[k].d, vecs[k].hold, o_res, o_c, o_z, o_dz, o_acc);
      check($sformatf("vec%0d_result", k), 32'(o_res), 32'(vecs[k].x_res));
      check($sformatf("vec%0d_carry", k),  32'(o_c),   32'(vecs[k].x_c));
      check($sformatf("vec%0d_zero", k),   32'(o_z),   32'(vecs[k].x_z));
      check($sformatf("vec%0d_div0", k),   32'(o_dz),  32'(vecs[k].x_dz));
      check($sformatf("vec%0d_acc", k),    32'(o_acc), 32'(vecs[k].x_acc));
    end

    // Reset during EXEC of an ADD abandons the command
    run_cmd(1'b1, 4'h0, 8'h55, 0, o_res, o_c, o_z, o_dz, o_acc);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'h0; cmd_data = 8'h01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("exec_reached", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_acc", 32'(acc), 32'h00);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 8'h00; e_a = 8'h00; e_b = 8'h00; e_op = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
      check("no_stale_ready", 32'(cmd_ready), 32'd1);
    end
    rsp_ready = 1'b0;
    check("post_rst_acc", 32'(acc), 32'h00);

    // Backpressure with the next command already waiting
    run_cmd(1'b1, 4'h0, 8'h33, 0, o_res, o_c, o_z, o_dz, o_acc);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'h0; cmd_data = 8'h05;
    model_cmd(1'b0, 4'h0, 8'h05, r, c, dz);
    @(posedge clk);
    @(negedge clk);
    cmd_op = 4'hA; cmd_data = 8'h0F;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    check("bp_latency", 32'(lat), 32'd2);
    check_rsp("bp", r, c, dz);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_rsp("bp_hold", r, c, dz);
      check("bp_alu_op", 32'(alu_operation), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_rsp_done", 32'(rsp_valid), 32'd0);
    check("bp_ready_after", 32'(cmd_ready), 32'd1);
    check("bp_not_yet_taken", 32'(alu_operation), 32'h0);
    model_cmd(1'b0, 4'hA, 8'h0F, r, c, dz);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp2_alu_op", 32'(alu_operation), 32'hA);
    check("bp2_alu_a", 32'(alu_operand_a), 32'(e_a));
    @(negedge clk);
    check("bp2_valid", 32'(rsp_valid), 32'd1);
    check_rsp("bp2", r, c, dz);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Random commands against the model
    for (int i = 0; i < 80; i++) begin
      logic ld;
      logic [3:0] op;
      logic [7:0] d;
      ld = ($urandom_range(0, 3) == 0);
      op = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_cmd(ld, op, d, $urandom_range(0, 2), o_res, o_c, o_z, o_dz, o_acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
